// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake to instruction
// memory and holds the fetched word for the main controller decoder.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_RST   | one idle cycle after reset release, no request
// ST_FETCH | imem_req high at pc, waiting for imem_ack
// ST_VALID | instr holds an unconsumed word, waiting for consume
// ST_HALT  | misaligned redirect seen, frozen until rst_n
module if_fetch_stage #(
    parameter int                XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic            misaligned
);

    localparam logic [1:0] ST_RST   = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    logic [1:0]      state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    logic            misaligned_q;
    logic            consume;

    assign consume = instr_ready & ~stall;

    // pc is the next fetch address; pc_q tags the word sitting in instr_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RST;
            pc           <= RESET_PC;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            misaligned_q <= 1'b0;
        end else begin
            case (state)
                ST_RST: begin
                    state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        pc_q    <= pc;
                        state   <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (consume) begin
                        if (!redirect) begin
                            pc    <= pc_q + XLEN'(4);
                            state <= ST_FETCH;
                        end else if (redirect_target[1:0] == 2'b00) begin
                            pc    <= redirect_target;
                            state <= ST_FETCH;
                        end else begin
                            misaligned_q <= 1'b1;
                            instr_q      <= NOP_INSTR;
                            state        <= ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_RST;
                end
            endcase
        end
    end

    assign imem_req    = (state == ST_FETCH);
    assign imem_addr   = pc;
    assign instr       = instr_q;
    assign opcode      = instr_q[6:0];
    assign pc_out      = pc_q;
    assign pc_plus4    = pc_q + XLEN'(4);
    assign instr_valid = (state == ST_VALID);
    assign misaligned  = misaligned_q;

endmodule
